// File: rtl/rgb_seq_pkg.sv
// rtl/rgb_seq_pkg.sv - shared mode and colour definitions for the RGB sequencer
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_CYCLE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // Colours are {r,g,b} enables; CYCLE mode walks them in index order.
    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

endpackage

// File: rtl/rgb_sequencer_tick_gen.sv
// rtl/rgb_sequencer_tick_gen.sv - divide-by-DIV tick generator with clear and enable
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int              W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]    LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A clear on the same edge suppresses the tick so the caller's clear wins.
    assign o_tick = i_en && !i_clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rgb_sequencer.sv
// rtl/rgb_sequencer.sv - RGB status LED driver with PWM, colour cycle and breathe modes
module rgb_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 24_000_000,
    parameter int BREATHE_DIV = 94_118,
    parameter int PWM_BITS    = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [1:0]          i_mode,
    input  logic [2:0]          i_colour,
    input  logic [PWM_BITS-1:0] i_brightness,
    input  logic                i_pause,
    output logic                o_ledr,
    output logic                o_ledg,
    output logic                o_ledb,
    output logic [2:0]          o_step,
    output logic                o_wrap
);

    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] RAMP_ONE = PWM_BITS'(1);

    mode_e               mode_q, mode_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [2:0]          step_q, step_d;
    logic [PWM_BITS-1:0] ramp_q, ramp_d;
    logic                up_q, up_d;
    logic                wrap_q, wrap_d;
    logic [2:0]          led_q, led_d;

    logic                mode_chg;
    logic                step_tick;
    logic                br_tick;
    logic [2:0]          colour;
    logic [PWM_BITS-1:0] duty;

    assign mode_chg = (mode_e'(i_mode) != mode_q);

    tick_gen #(.DIV(STEP_CYCLES)) u_step_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (mode_chg),
        .i_en   ((mode_q == MODE_CYCLE) && !i_pause),
        .o_tick (step_tick)
    );

    tick_gen #(.DIV(BREATHE_DIV)) u_breathe_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (mode_chg),
        .i_en   ((mode_q == MODE_BREATHE) && !i_pause),
        .o_tick (br_tick)
    );

    // Reset adopts the requested mode so release is not mistaken for a mode change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q <= mode_e'(i_mode);
            pwm_q  <= '0;
            step_q <= BLACK;
            ramp_q <= '0;
            up_q   <= 1'b1;
            wrap_q <= 1'b0;
            led_q  <= BLACK;
        end else begin
            mode_q <= mode_d;
            pwm_q  <= pwm_d;
            step_q <= step_d;
            ramp_q <= ramp_d;
            up_q   <= up_d;
            wrap_q <= wrap_d;
            led_q  <= led_d;
        end
    end

    always_comb begin
        mode_d = mode_e'(i_mode);
        pwm_d  = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
        step_d = step_q;
        ramp_d = ramp_q;
        up_d   = up_q;
        wrap_d = 1'b0;
        if (mode_chg) begin
            step_d = BLACK;
            ramp_d = '0;
            up_d   = 1'b1;
        end else begin
            if (step_tick) begin
                step_d = (step_q == WHITE) ? BLACK : step_q + 3'd1;
                wrap_d = (step_q == WHITE);
            end
            // Direction flips on the tick that lands on the top or bottom level.
            if (br_tick) begin
                if (up_q) begin
                    ramp_d = ramp_q + 1'b1;
                    up_d   = (ramp_q != PWM_LAST);
                end else begin
                    ramp_d = ramp_q - 1'b1;
                    up_d   = (ramp_q == RAMP_ONE);
                    wrap_d = (ramp_q == RAMP_ONE);
                end
            end
        end
    end

    always_comb begin
        colour = BLACK;
        duty   = '0;
        case (mode_q)
            MODE_STATIC: begin
                colour = i_colour;
                duty   = i_brightness;
            end
            MODE_CYCLE: begin
                colour = step_q;
                duty   = i_brightness;
            end
            MODE_BREATHE: begin
                colour = i_colour;
                duty   = ramp_q;
            end
            default: begin
                colour = BLACK;
                duty   = '0;
            end
        endcase
        led_d = colour & {3{pwm_q < duty}};
    end

    assign o_ledr = led_q[2];
    assign o_ledg = led_q[1];
    assign o_ledb = led_q[0];
    assign o_step = step_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// tb/tb_rgb_sequencer.sv - scoreboard bench for rgb_sequencer
module tb_rgb_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [2:0] colour;
    logic [2:0] bright;
    logic       pause;
    logic       ledr, ledg, ledb;
    logic [2:0] step;
    logic       wrap;

    int tests = 0;
    int fails = 0;
    int cyc_no = 0;
    int pw = 0;

    typedef struct {
        int         id;
        logic [2:0] led;
        logic [2:0] stp;
        logic       wrp;
        bit         chk_led;
        bit         chk_stp;
    } exp_t;

    exp_t sb[$];

    rgb_sequencer #(
        .STEP_CYCLES (4),
        .BREATHE_DIV (2),
        .PWM_BITS    (3)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mode       (mode),
        .i_colour     (colour),
        .i_brightness (bright),
        .i_pause      (pause),
        .o_ledr       (ledr),
        .o_ledg       (ledg),
        .o_ledb       (ledb),
        .o_step       (step),
        .o_wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Expected LED value uses the PWM phase before the coming edge; pw tracks that phase.
    task automatic cyc(input logic [2:0] col, input int duty, input int stp,
                       input bit wrp, input bit chk_led, input bit chk_stp);
        exp_t e;
        e.id      = cyc_no;
        e.led     = (pw < duty) ? col : 3'b000;
        e.stp     = 3'(stp);
        e.wrp     = wrp;
        e.chk_led = chk_led;
        e.chk_stp = chk_stp;
        sb.push_back(e);
        pw = rst ? 0 : ((pw == 6) ? 0 : pw + 1);
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic cycle_run(input int n0, input int n1);
        for (int n = n0; n <= n1; n++) begin
            cyc(3'(((n - 1) / 4) % 8), 7, (n / 4) % 8, (n % 32) == 0, 1'b1, 1'b1);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_led) begin
                tests++;
                if ({ledr, ledg, ledb} !== e.led) begin
                    fails++;
                    $display("FAIL led cyc=%0d got=%b exp=%b", e.id, {ledr, ledg, ledb}, e.led);
                end
            end
            if (e.chk_stp) begin
                tests++;
                if (step !== e.stp) begin
                    fails++;
                    $display("FAIL step cyc=%0d got=%0d exp=%0d", e.id, step, e.stp);
                end
            end
            tests++;
            if (wrap !== e.wrp) begin
                fails++;
                $display("FAIL wrap cyc=%0d got=%b exp=%b", e.id, wrap, e.wrp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        mode   = 2'd2;
        colour = 3'b000;
        bright = 3'd7;
        pause  = 1'b0;

        repeat (2) cyc(3'b000, 0, 0, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        cycle_run(1, 6);

        rst = 1'b1;
        repeat (3) cyc(3'b000, 0, 0, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        cycle_run(1, 10);

        mode   = 2'd1;
        colour = 3'b101;
        bright = 3'd3;
        cyc(3'b000, 0, 0, 1'b0, 1'b0, 1'b1);
        repeat (14) cyc(3'b101, 3, 0, 1'b0, 1'b1, 1'b1);
        bright = 3'd0;
        repeat (8) cyc(3'b101, 0, 0, 1'b0, 1'b1, 1'b1);
        bright = 3'd7;
        repeat (8) cyc(3'b101, 7, 0, 1'b0, 1'b1, 1'b1);

        mode = 2'd2;
        cyc(3'b000, 0, 0, 1'b0, 1'b0, 1'b1);
        cycle_run(1, 45);

        pause  = 1'b1;
        bright = 3'd3;
        repeat (10) cyc(3'b011, 3, 3, 1'b0, 1'b1, 1'b1);
        pause  = 1'b0;
        bright = 3'd7;
        cycle_run(46, 51);

        // Step tick would fire on this edge; the mode-change clear must win.
        mode   = 2'd3;
        colour = 3'b010;
        bright = 3'd0;
        cyc(3'b000, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int m = 1; m <= 60; m++) begin
            int t;
            int r;
            t = ((m - 1) / 2) % 14;
            r = (t <= 7) ? t : 14 - t;
            cyc(3'b010, r, 0, (m % 28) == 0, 1'b1, 1'b1);
        end

        mode = 2'd0;
        cyc(3'b000, 0, 0, 1'b0, 1'b0, 1'b1);
        repeat (8) cyc(3'b000, 0, 0, 1'b0, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
